pic_ctrl: RTL and testbench
===========================

# pic_ctrl

Instruction sequencer and decoder for the PIC10F200 core. Splits each instruction cycle into four clock phases (Q1–Q4). Owns the program counter, the instruction register and the 2-level return stack. Decodes the executing instruction into datapath controls, including `sel` for the downstream 8-bit operand mux: 0 selects the file-register value (`in0`), 1 selects the literal (`in1`). Fetch of the next word overlaps execution of the current one.

## Interface
Parameters:
- RESET_PC, 8'hFF: PC value after reset; the reset vector.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- instr  in  12  program-memory word at address `pc`
- alu_zero  in  1  ALU result-is-zero; used by DECFSZ/INCFSZ
- bit_val  in  1  value of the addressed file bit; used by BTFSC/BTFSS
- pc  out  8  program-memory address; reset RESET_PC
- ir  out  12  executing instruction; reset 12'h000
- exec_valid  out  1  `ir` is a real instruction, not a flush bubble; reset 0
- q  out  2  phase counter (0=Q1 … 3=Q4); reset 0
- sel  out  1  operand mux select (1 = literal); reset 0
- literal  out  8  `ir[7:0]`
- f_addr  out  5  `ir[4:0]`
- alu_op  out  5  ALU operation code
- w_we  out  1  W write strobe; reset 0
- f_we  out  1  file-register write strobe; reset 0

## Operation
- `q` counts 0→1→2→3→0, one step per clock. One instruction cycle is 4 clocks.
- `sel`, `alu_op`, `literal` and `f_addr` are combinational from `ir`. They are stable for all four phases.
- Decode, on `ir`:
  - NOP 000000000000: no writes.
  - MOVWF 0000001fffff: f_we, alu_op 00000 (pass W).
  - CLRW 000001000000: w_we, alu_op 00001.
  - CLRF 0000011fffff: f_we, alu_op 00001.
  - Byte ops 00oooodfffff with ir[9:6] ≥ 0010: alu_op {0, ir[9:6]}, sel 0. d=ir[5]: 0 gives w_we, 1 gives f_we.
  - Bit ops 01oobbbfffff: alu_op {110, ir[9:8]}, sel 0. BCF and BSF assert f_we. BTFSC and BTFSS perform no write.
  - RETLW 1000kkkkkkkk: w_we, sel 1, alu_op 01000.
  - CALL 1001kkkkkkkk and GOTO 101kkkkkkkkk: no writes.
  - MOVLW/IORLW/ANDLW/XORLW (ir[11:8] = 1100/1101/1110/1111): w_we, sel 1, alu_op 01000/00100/00101/00110.
  - All other encodings (OPTION, SLEEP, CLRWDT, TRIS): NOP.
- Write strobes: `w_we`/`f_we` = decode & exec_valid & (q==3) & !rst. Each is exactly one clock wide per instruction.
- On the clock edge ending Q4:
  - next pc:
    - GOTO: `ir[7:0]`.
    - CALL: `ir[7:0]`, and push `pc`.
    - RETLW: pop.
    - Otherwise: `pc`+1, wrapping 8'hFF→8'h00.
  - `ir` <= flush ? 12'h000 : instr.
  - `exec_valid` <= !flush.
- flush = exec_valid & (GOTO | CALL | RETLW | skip_taken).
- skip_taken = ((DECFSZ|INCFSZ) & alu_zero) | (BTFSC & !bit_val) | (BTFSS & bit_val). It is sampled in Q4.
- A skip does not alter the pc sequence. It only bubbles the already-fetched word.
- Stack:
  - Push: s1<=s0, s0<=pc. A third push discards the oldest entry.
  - Pop: pc<=s0, s0<=s1, s1 unchanged. Popping an empty stack returns the stale s0.
  - Both entries reset to 8'h00.
- Flushed or invalid cycles never push or pop.

## Timing
- Reset:
  - Every register takes its reset value on the first clock edge with rst=1.
  - Write strobes are low for the whole time rst is high, including mid-Q4.
- First instruction after reset:
  - `pc`=FF for 4 clocks.
  - The first Q4 edge loads `ir`=mem[FF], `pc`=00, exec_valid=1.
- During execution of the instruction at address A, `pc` = A+1.
- Cost per instruction:
  - Normal instruction: 4 clocks.
  - GOTO, CALL, RETLW and a taken skip: 8 clocks (the instruction plus one bubble cycle).
- Branch target: the target word is in `ir` 8 clocks after the branch enters `ir`.

## Test plan
- Reset, then run MOVLW 8'h5A at FF:
  - exec_valid=0 for clocks 1–4.
  - Then ir=12'hC5A, sel=1, literal=5A.
  - w_we high only in Q4; pc=00.
- ADDWF f=0x10, d=1:
  - sel=0, alu_op=00111, f_addr=10.
  - f_we pulses one clock in Q4; w_we stays 0.
- GOTO 0x20 at address 05:
  - Next cycle exec_valid=0, no strobes.
  - The following cycle executes mem[20]; pc=21.
- CALL 0x40 at 03, then RETLW 8'h77 at 40:
  - Stack s0=04 after the CALL.
  - RETLW asserts w_we with sel=1, literal=77.
  - pc returns to 04 after the bubble.
- Skips:
  - DECFSZ with alu_zero=1 in Q4: next instruction bubbled.
  - DECFSZ with alu_zero=0: next instruction executes.
  - BTFSS with bit_val=1: bubbled.
- Wrap and reset:
  - pc FF→00 wraps correctly.
  - Three CALLs, then two RETLWs return the 3rd and 2nd addresses.
  - rst asserted during Q3: the next edge shows q=0, pc=FF, exec_valid=0, and no write strobes.

Source files
------------

// File: rtl/pic_ctrl.sv
// pic_ctrl: four-phase instruction sequencer and decoder for a PIC10F200-class
// core. Owns pc, ir and the two-entry return stack; the next word is fetched
// while the current one executes, and control-flow changes bubble that word.
module pic_ctrl #(
    parameter logic [7:0] RESET_PC = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] instr,
    input  logic        alu_zero,
    input  logic        bit_val,
    output logic [7:0]  pc,
    output logic [11:0] ir,
    output logic        exec_valid,
    output logic [1:0]  q,
    output logic        sel,
    output logic [7:0]  literal,
    output logic [4:0]  f_addr,
    output logic [4:0]  alu_op,
    output logic        w_we,
    output logic        f_we
);

    logic [7:0] s0, s1;
    logic       dec_w, dec_f;
    logic       is_goto, is_call, is_retlw, is_fsz, is_btfsc, is_btfss;
    logic       skip_taken, flush, q4;

    assign literal = ir[7:0];
    assign f_addr  = ir[4:0];
    assign q4      = (q == 2'd3);

    // Decode the executing word into datapath controls and flow-control flags.
    always_comb begin
        dec_w    = 1'b0;
        dec_f    = 1'b0;
        sel      = 1'b0;
        alu_op   = 5'b00000;
        is_goto  = 1'b0;
        is_call  = 1'b0;
        is_retlw = 1'b0;
        is_fsz   = 1'b0;
        is_btfsc = 1'b0;
        is_btfss = 1'b0;
        case (ir[11:10])
            2'b00: begin
                if (ir[9:6] >= 4'b0010) begin
                    // Byte-oriented file ops; d chooses the destination.
                    alu_op = {1'b0, ir[9:6]};
                    dec_f  = ir[5];
                    dec_w  = ~ir[5];
                    is_fsz = (ir[9:6] == 4'b1011) || (ir[9:6] == 4'b1111);
                end else if (ir[9:5] == 5'b00001) begin
                    dec_f  = 1'b1;                 // MOVWF, ALU passes W
                end else if (ir[9:5] == 5'b00011) begin
                    dec_f  = 1'b1;                 // CLRF
                    alu_op = 5'b00001;
                end else if (ir[9:0] == 10'b0001000000) begin
                    dec_w  = 1'b1;                 // CLRW
                    alu_op = 5'b00001;
                end
                // Remaining 0000_00xx_xxxx words (OPTION, SLEEP, ...) act as NOP.
            end
            2'b01: begin
                alu_op   = {3'b110, ir[9:8]};
                dec_f    = ~ir[9];                 // BCF / BSF
                is_btfsc = (ir[9:8] == 2'b10);
                is_btfss = (ir[9:8] == 2'b11);
            end
            2'b10: begin
                if (ir[9]) begin
                    is_goto = 1'b1;
                end else if (ir[8]) begin
                    is_call = 1'b1;
                end else begin
                    is_retlw = 1'b1;
                    dec_w    = 1'b1;
                    sel      = 1'b1;
                    alu_op   = 5'b01000;
                end
            end
            default: begin
                dec_w = 1'b1;
                sel   = 1'b1;
                case (ir[9:8])
                    2'b00:   alu_op = 5'b01000;    // MOVLW
                    2'b01:   alu_op = 5'b00100;    // IORLW
                    2'b10:   alu_op = 5'b00101;    // ANDLW
                    default: alu_op = 5'b00110;    // XORLW
                endcase
            end
        endcase
    end

    assign skip_taken = (is_fsz & alu_zero) | (is_btfsc & ~bit_val) | (is_btfss & bit_val);
    assign flush      = exec_valid & (is_goto | is_call | is_retlw | skip_taken);

    // Strobes fire once per real instruction, in Q4, and never while in reset.
    assign w_we = dec_w & exec_valid & q4 & ~rst;
    assign f_we = dec_f & exec_valid & q4 & ~rst;

    // Phase counter, pc, instruction register and valid flag; Q4 edge retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            q          <= 2'd0;
            pc         <= RESET_PC;
            ir         <= 12'h000;
            exec_valid <= 1'b0;
        end else begin
            q <= q + 2'd1;
            if (q4) begin
                ir         <= flush ? 12'h000 : instr;
                exec_valid <= ~flush;
                if (exec_valid && (is_goto || is_call))
                    pc <= ir[7:0];
                else if (exec_valid && is_retlw)
                    pc <= s0;
                else
                    pc <= pc + 8'd1;
            end
        end
    end

    // Two-entry return stack: push drops the oldest, pop leaves s1 in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 8'h00;
            s1 <= 8'h00;
        end else if (q4 && exec_valid) begin
            if (is_call) begin
                s1 <= s0;
                s0 <= pc;
            end else if (is_retlw) begin
                s0 <= s1;
            end
        end
    end

endmodule

// File: tb/tb_pic_ctrl.sv
// Scoreboard bench for pic_ctrl: an instruction-cycle reference model fills a
// queue of expected cycles while a monitor checks every clock against it.
module tb_pic_ctrl;

    localparam int NCYC = 400;
    localparam bit [2:0] K_NONE = 3'd0, K_GOTO = 3'd1, K_CALL = 3'd2,
                         K_RET = 3'd3, K_FSZ = 3'd4, K_BTFSC = 3'd5, K_BTFSS = 3'd6;

    logic        clk = 1'b0;
    logic        rst, alu_zero, bit_val;
    logic [11:0] instr, ir;
    logic [7:0]  pc, literal;
    logic        exec_valid, sel, w_we, f_we;
    logic [1:0]  q;
    logic [4:0]  f_addr, alu_op;

    logic [11:0] mem [256];
    assign instr = mem[pc];

    pic_ctrl #(.RESET_PC(8'hFF)) dut (
        .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .bit_val(bit_val),
        .pc(pc), .ir(ir), .exec_valid(exec_valid), .q(q), .sel(sel),
        .literal(literal), .f_addr(f_addr), .alu_op(alu_op), .w_we(w_we), .f_we(f_we)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       wwe, fwe, care, sel;
        bit [4:0] alu;
        bit [2:0] kind;
    } dec_t;

    typedef struct {
        logic [7:0]  pc;
        logic [11:0] ir;
        logic        ev, wwe, fwe, care, sel;
        logic [4:0]  alu;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, failures = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    // Reference decode from the instruction-set table (mnemonic by mnemonic).
    function automatic dec_t ref_decode(input logic [11:0] w);
        dec_t d = '0;
        if (w[11:10] == 2'b00 && w[9:6] >= 4'd2) begin
            d.alu = {1'b0, w[9:6]}; d.care = 1'b1;
            if (w[5]) d.fwe = 1'b1; else d.wwe = 1'b1;
            if (w[9:6] == 4'hB || w[9:6] == 4'hF) d.kind = K_FSZ;
        end else if (w[11:5] == 7'b0000001) begin
            d.fwe = 1'b1; d.care = 1'b1; d.alu = 5'b00000;
        end else if (w[11:5] == 7'b0000011) begin
            d.fwe = 1'b1; d.care = 1'b1; d.alu = 5'b00001;
        end else if (w == 12'h040) begin
            d.wwe = 1'b1; d.care = 1'b1; d.alu = 5'b00001;
        end else if (w[11:10] == 2'b01) begin
            d.care = 1'b1; d.alu = {3'b110, w[9:8]};
            case (w[9:8])
                2'd0, 2'd1: d.fwe = 1'b1;
                2'd2:       d.kind = K_BTFSC;
                default:    d.kind = K_BTFSS;
            endcase
        end else if (w[11:8] == 4'h8) begin
            d.wwe = 1'b1; d.sel = 1'b1; d.care = 1'b1; d.alu = 5'b01000; d.kind = K_RET;
        end else if (w[11:8] == 4'h9) begin
            d.kind = K_CALL;
        end else if (w[11:9] == 3'b101) begin
            d.kind = K_GOTO;
        end else if (w[11:10] == 2'b11) begin
            d.wwe = 1'b1; d.sel = 1'b1; d.care = 1'b1;
            case (w[9:8])
                2'd0:    d.alu = 5'b01000;
                2'd1:    d.alu = 5'b00100;
                2'd2:    d.alu = 5'b00101;
                default: d.alu = 5'b00110;
            endcase
        end
        return d;
    endfunction

    function automatic logic [11:0] rand_instr();
        logic [11:0] w;
        case ($urandom_range(0, 11))
            0:  w = {2'b00, 4'($urandom_range(2, 15)), 6'($urandom)};
            1:  w = {2'b00, ($urandom_range(0, 1) != 0) ? 4'hB : 4'hF, 6'($urandom)};
            2:  w = {2'b01, 10'($urandom)};
            3:  w = {4'h8, 8'($urandom)};
            4:  w = {4'h9, 8'($urandom)};
            5:  w = {3'b101, 9'($urandom)};
            6, 7: w = {2'b11, 10'($urandom)};
            8:  w = {7'b0000001, 5'($urandom)};
            9:  w = {7'b0000011, 5'($urandom)};
            10: w = 12'h040;
            default: w = 12'($urandom);
        endcase
        return w;
    endfunction

    // Monitor: one sample per clock, away from the edge; Q4 retires an entry.
    initial begin
        int   mq = 0;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!mon_en) begin
                mq = 0;
            end else if (sbq.size() == 0) begin
                chk("sb_empty", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq[0];
                chk("q", 32'(q), 32'(mq));
                chk("pc", 32'(pc), 32'(e.pc));
                chk("ir", 32'(ir), 32'(e.ir));
                chk("exec_valid", 32'(exec_valid), 32'(e.ev));
                chk("literal", 32'(literal), 32'(e.ir[7:0]));
                chk("f_addr", 32'(f_addr), 32'(e.ir[4:0]));
                if (e.care) begin
                    chk("sel", 32'(sel), 32'(e.sel));
                    chk("alu_op", 32'(alu_op), 32'(e.alu));
                end
                chk("w_we", 32'(w_we), 32'((mq == 3) ? e.wwe : 1'b0));
                chk("f_we", 32'(f_we), 32'((mq == 3) ? e.fwe : 1'b0));
                if (mq == 3) void'(sbq.pop_front());
                mq = (mq + 1) % 4;
            end
        end
    end

    // Driver and instruction-level reference model.
    initial begin
        logic [7:0]  m_pc, nxt, s0, s1;
        logic [11:0] m_ir;
        logic        m_v, flush;
        dec_t        d;
        exp_t        e;

        foreach (mem[i]) mem[i] = rand_instr();
        mem[8'hFF] = 12'hC5A;   // MOVLW 5A
        mem[8'h00] = 12'h1F0;   // ADDWF 0x10,1
        mem[8'h01] = 12'h2E5;   // DECFSZ 0x05,1
        mem[8'h02] = 12'h723;   // BTFSS 0x03,1
        mem[8'h03] = 12'h940;   // CALL 40
        mem[8'h04] = 12'h941;   // CALL 41
        mem[8'h05] = 12'hA20;   // GOTO 20
        mem[8'h40] = 12'h877;   // RETLW 77
        mem[8'h41] = 12'h942;   // CALL 42
        mem[8'h42] = 12'h811;   // RETLW 11
        mem[8'h43] = 12'h822;   // RETLW 22

        rst = 1'b1; alu_zero = 1'b0; bit_val = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_pc", 32'(pc), 32'hFF);
        chk("rst_ir", 32'(ir), 32'h000);
        chk("rst_ev", 32'(exec_valid), 32'd0);
        chk("rst_strobes", 32'({w_we, f_we}), 32'd0);

        rst = 1'b0;
        m_pc = 8'hFF; m_ir = 12'h000; m_v = 1'b0; s0 = 8'h00; s1 = 8'h00;
        mon_en = 1'b1;
        for (int n = 0; n < NCYC; n++) begin
            d = ref_decode(m_ir);
            e.pc = m_pc; e.ir = m_ir; e.ev = m_v;
            e.wwe = d.wwe & m_v; e.fwe = d.fwe & m_v;
            e.care = d.care; e.sel = d.sel; e.alu = d.alu;
            sbq.push_back(e);
            alu_zero = 1'($urandom_range(0, 1));
            bit_val  = 1'($urandom_range(0, 1));
            flush = 1'b0;
            nxt = m_pc + 8'd1;
            if (m_v) begin
                case (d.kind)
                    K_GOTO:  begin nxt = m_ir[7:0]; flush = 1'b1; end
                    K_CALL:  begin s1 = s0; s0 = m_pc; nxt = m_ir[7:0]; flush = 1'b1; end
                    K_RET:   begin nxt = s0; s0 = s1; flush = 1'b1; end
                    K_FSZ:   flush = alu_zero;
                    K_BTFSC: flush = ~bit_val;
                    K_BTFSS: flush = bit_val;
                    default: flush = 1'b0;
                endcase
            end
            m_ir = flush ? 12'h000 : mem[m_pc];
            m_v  = ~flush;
            m_pc = nxt;
            repeat (4) @(negedge clk);
        end
        mon_en = 1'b0;
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        // Reset landing in Q3 of an arbitrary cycle.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_q", 32'(q), 32'd0);
        chk("midrst_pc", 32'(pc), 32'hFF);
        chk("midrst_ev", 32'(exec_valid), 32'd0);
        chk("midrst_strobes", 32'({w_we, f_we}), 32'd0);

        // Restart, reach Q4 of MOVLW 5A, then reset during that Q4.
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        chk("q4_q", 32'(q), 32'd3);
        chk("q4_ir", 32'(ir), 32'hC5A);
        chk("q4_pc", 32'(pc), 32'h00);
        chk("q4_w_we", 32'(w_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("q4rst_w_we", 32'(w_we), 32'd0);
        @(posedge clk); #1;
        chk("q4rst_pc", 32'(pc), 32'hFF);
        chk("q4rst_ev", 32'(exec_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
